// File: rtl/sink_port_pkg.sv
// Shared constants and helpers for the NoC sink port: flit/packet geometry and pair codes.
package sink_port_pkg;

  localparam int FLIT_W    = 32;
  localparam int N_FLITS   = 5;
  localparam int PKT_W     = N_FLITS * FLIT_W;
  localparam int CHANNEL_W = 32;

  localparam logic [1:0] PAIR_A = 2'b10;
  localparam logic [1:0] PAIR_B = 2'b01;

  typedef logic [PKT_W-1:0] packet_t;

  function automatic logic pair_valid(input logic [1:0] p);
    return (p == PAIR_A) || (p == PAIR_B);
  endfunction

endpackage

// File: rtl/sink_port_pkt_fifo.sv
// pkt_fifo: synchronous first-word-fall-through packet FIFO, any DEPTH >= 1.
// Occupancy lives in its own counter so pointers can wrap at non-power-of-two depths.
module pkt_fifo #(
  parameter int WIDTH = 160,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  // A push into a full FIFO is only taken when the head leaves on the same edge.
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

  assign o_dat   = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= ptr_next(r_wr_ptr);
      end
      if (w_do_pop) r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sink_port.sv
// sink_port: NoC link receive end - pair-toggle framing, 5-flit assembly, packet FIFO, credit return.
// Defining SINK_PORT_RX_STATS_EN adds pkt_count, sticky err_overflow and sticky err_pair outputs.
module sink_port
  import sink_port_pkg::*;
#(
  parameter int CREDITS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           diff_pair_in,
  input  logic [CHANNEL_W-1:0] channel_in,
  output logic                 credit_out,
  output logic                 pkt_valid,
  input  logic                 pkt_ready,
  output logic [PKT_W-1:0]     pkt_data
`ifdef SINK_PORT_RX_STATS_EN
  ,
  output logic [31:0]          pkt_count,
  output logic                 err_overflow,
  output logic                 err_pair
`endif
);

  localparam int FC_W  = $clog2(N_FLITS);
  localparam int ASM_W = (N_FLITS - 1) * FLIT_W;

  typedef enum logic {ST_IDLE, ST_RECV} state_t;

  state_t            r_state;
  logic [FC_W-1:0]   r_flit_cnt;
  logic [1:0]        r_last_pair;
  logic [ASM_W-1:0]  r_asm;
  logic              r_credit;

  logic [FLIT_W-1:0] w_flit;
  logic              w_start;
  logic              w_capture;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  packet_t           w_pkt;

  assign w_flit    = channel_in[FLIT_W-1:0];
  assign w_start   = (r_state == ST_IDLE) && pair_valid(diff_pair_in) && (diff_pair_in != r_last_pair);
  assign w_capture = w_start || (r_state == ST_RECV);
  assign w_push    = (r_state == ST_RECV) && (r_flit_cnt == FC_W'(N_FLITS - 1));
  assign w_pop     = pkt_valid && pkt_ready;

  // Flits enter at the top and shift down, so flit0 ends up in the low word.
  assign w_pkt      = {w_flit, r_asm};
  assign pkt_valid  = !w_empty;
  assign credit_out = r_credit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_flit_cnt  <= '0;
      r_last_pair <= PAIR_A;
      r_asm       <= '0;
      r_credit    <= 1'b0;
    end else begin
      r_credit <= w_pop;
      if (w_capture) r_asm <= {w_flit, r_asm[ASM_W-1:FLIT_W]};
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_last_pair <= diff_pair_in;
            r_flit_cnt  <= FC_W'(1);
            r_state     <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (w_push) begin
            r_flit_cnt <= '0;
            r_state    <= ST_IDLE;
          end else begin
            r_flit_cnt <= r_flit_cnt + FC_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  pkt_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (CREDITS)
  ) u_fifo (
    .clk        (clk),
    .rst        (reset),
    .i_push     (w_push),
    .i_push_dat (w_pkt),
    .i_pop      (w_pop),
    .o_dat      (pkt_data),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

`ifdef SINK_PORT_RX_STATS_EN
  logic [31:0] r_pkt_count;
  logic        r_err_overflow;
  logic        r_err_pair;
  logic        w_drop;

  assign w_drop = w_push && w_full && !w_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pkt_count    <= '0;
      r_err_overflow <= 1'b0;
      r_err_pair     <= 1'b0;
    end else begin
      if (w_push && !w_drop) r_pkt_count <= r_pkt_count + 32'd1;
      if (w_drop) r_err_overflow <= 1'b1;
      if (!pair_valid(diff_pair_in)) r_err_pair <= 1'b1;
    end
  end

  assign pkt_count    = r_pkt_count;
  assign err_overflow = r_err_overflow;
  assign err_pair     = r_err_pair;
`else
  // Without stats an overflow simply loses the packet.
  logic w_unused_full;
  assign w_unused_full = w_full;
`endif

endmodule

// File: tb/tb_sink_port.sv
// Scoreboard bench for sink_port: expected packets queued as they are sent, checked as they are popped.
module tb_sink_port;
  import sink_port_pkg::*;

  localparam int CREDITS = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0]           diff_pair_in;
  logic [CHANNEL_W-1:0] channel_in;
  logic                 credit_out;
  logic                 pkt_valid;
  logic                 pkt_ready;
  packet_t              pkt_data;
`ifdef SINK_PORT_RX_STATS_EN
  logic [31:0]          pkt_count;
  logic                 err_overflow;
  logic                 err_pair;
`endif

  sink_port #(.CREDITS(CREDITS)) dut (
    .clk          (clk),
    .reset        (reset),
    .diff_pair_in (diff_pair_in),
    .channel_in   (channel_in),
    .credit_out   (credit_out),
    .pkt_valid    (pkt_valid),
    .pkt_ready    (pkt_ready),
    .pkt_data     (pkt_data)
`ifdef SINK_PORT_RX_STATS_EN
    ,
    .pkt_count    (pkt_count),
    .err_overflow (err_overflow),
    .err_pair     (err_pair)
`endif
  );

  always #5 clk = ~clk;

  int      n_checks = 0;
  int      n_errors = 0;
  int      n_credit = 0;
  int      n_pushed = 0;
  int      c0;
  packet_t exp_q[$];
  packet_t exp_p;
  logic [1:0] cur_pair;
  logic    prev_pop = 1'b0;

  task automatic chk(input string tag, input logic [PKT_W-1:0] got, input logic [PKT_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Monitor on the falling edge: inputs and outputs are stable mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      prev_pop = 1'b0;
    end else begin
      chk("credit_out", PKT_W'(credit_out), PKT_W'(prev_pop));
      if (credit_out) n_credit++;
      chk("pkt_valid", PKT_W'(pkt_valid), PKT_W'(exp_q.size() != 0));
      prev_pop = (exp_q.size() != 0) && pkt_ready;
      if (prev_pop) begin
        exp_p = exp_q.pop_front();
        chk("pkt_data", pkt_data, exp_p);
      end
    end
  end

  // rdy_last < 0 leaves pkt_ready alone on the last-flit cycle.
  task automatic send_pkt(input logic [31:0] base, input int rdy_last, input bit glitch);
    logic [1:0]  np;
    logic [31:0] f;
    packet_t     p;
    bit          drop;
    np   = (cur_pair == PAIR_A) ? PAIR_B : PAIR_A;
    drop = 1'b0;
    p    = '0;
    for (int i = 0; i < N_FLITS; i++) begin
      f = base + 32'(i);
      p[i*FLIT_W +: FLIT_W] = f;
      channel_in   = f;
      diff_pair_in = np;
      if (glitch && i == 2) diff_pair_in = cur_pair;
      if (glitch && i == 3) diff_pair_in = 2'b11;
      if (i == N_FLITS - 1) begin
        if (rdy_last >= 0) pkt_ready = (rdy_last != 0);
        drop = (exp_q.size() == CREDITS) && !((exp_q.size() != 0) && pkt_ready);
      end
      cyc();
    end
    diff_pair_in = np;
    cur_pair     = np;
    if (!drop) begin
      exp_q.push_back(p);
      n_pushed++;
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    diff_pair_in = PAIR_A;
    channel_in   = '0;
    pkt_ready    = 1'b0;
    cur_pair     = PAIR_A;
    #1;
    chk("rst_valid", PKT_W'(pkt_valid), '0);
    chk("rst_credit", PKT_W'(credit_out), '0);
    chk("rst_data", pkt_data, '0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Single packet, consumer ready
    pkt_ready = 1'b1;
    c0 = n_credit;
    send_pkt(32'd1, -1, 1'b0);
    chk("t1_valid_lat", PKT_W'(pkt_valid), PKT_W'(1));
    chk("t1_head", pkt_data, {32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
    repeat (3) cyc();
    chk("t1_credits", PKT_W'(n_credit - c0), PKT_W'(1));

    // Back-to-back, consumer stalled then released
    pkt_ready = 1'b0;
    c0 = n_credit;
    send_pkt(32'h100, -1, 1'b0);
    send_pkt(32'h200, -1, 1'b0);
    repeat (4) cyc();
    chk("t2_no_credit", PKT_W'(n_credit - c0), '0);
    chk("t2_head", pkt_data[31:0], PKT_W'(32'h100));
    pkt_ready = 1'b1;
    repeat (4) cyc();
    chk("t2_credits", PKT_W'(n_credit - c0), PKT_W'(2));

    // Overflow: third packet dropped, first still at head
    pkt_ready = 1'b0;
    send_pkt(32'h300, -1, 1'b0);
    send_pkt(32'h400, -1, 1'b0);
    send_pkt(32'h500, -1, 1'b0);
    cyc();
    chk("t3_head", pkt_data[31:0], PKT_W'(32'h300));
`ifdef SINK_PORT_RX_STATS_EN
    chk("t3_err_ovf", PKT_W'(err_overflow), PKT_W'(1));
    chk("t3_pkt_count", PKT_W'(pkt_count), PKT_W'(n_pushed));
`endif

    // Full with a pop on the same edge as the push
    c0 = n_credit;
    send_pkt(32'h600, 1, 1'b0);
    pkt_ready = 1'b0;
    chk("t4_head", pkt_data[31:0], PKT_W'(32'h400));
    repeat (3) cyc();
    chk("t4_credits", PKT_W'(n_credit - c0), PKT_W'(1));
`ifdef SINK_PORT_RX_STATS_EN
    chk("t4_pkt_count", PKT_W'(pkt_count), PKT_W'(n_pushed));
`endif
    pkt_ready = 1'b1;
    repeat (4) cyc();

    // Reset mid-packet while a credit pulse and a buffered packet are live
    pkt_ready = 1'b0;
    send_pkt(32'h700, -1, 1'b0);
    send_pkt(32'h800, -1, 1'b0);
    diff_pair_in = (cur_pair == PAIR_A) ? PAIR_B : PAIR_A;
    channel_in   = 32'h900;
    cyc();
    channel_in   = 32'h901;
    pkt_ready    = 1'b1;
    cyc();
    pkt_ready    = 1'b0;
    chk("t5_pre_credit", PKT_W'(credit_out), PKT_W'(1));
    reset        = 1'b1;
    diff_pair_in = PAIR_A;
    #1;
    chk("t5_rst_valid", PKT_W'(pkt_valid), '0);
    chk("t5_rst_credit", PKT_W'(credit_out), '0);
    exp_q.delete();
    cur_pair = PAIR_A;
    n_pushed = 0;
    cyc();
    cyc();
    reset = 1'b0;
`ifdef SINK_PORT_RX_STATS_EN
    chk("t5_err_ovf_clr", PKT_W'(err_overflow), '0);
    chk("t5_err_pair_clr", PKT_W'(err_pair), '0);
`endif
    cyc();
    chk("t5_idle", PKT_W'(pkt_valid), '0);
    send_pkt(32'hA00, -1, 1'b0);
    chk("t5_head", pkt_data, {32'hA04, 32'hA03, 32'hA02, 32'hA01, 32'hA00});
    pkt_ready = 1'b1;
    repeat (3) cyc();

    // Invalid pair codes in IDLE, then pair activity during RECV
    pkt_ready    = 1'b0;
    diff_pair_in = 2'b11;
    cyc();
    diff_pair_in = cur_pair;
    cyc();
    diff_pair_in = 2'b00;
    cyc();
    diff_pair_in = cur_pair;
    repeat (8) cyc();
    chk("t6_no_capture", PKT_W'(pkt_valid), '0);
`ifdef SINK_PORT_RX_STATS_EN
    chk("t6_err_pair", PKT_W'(err_pair), PKT_W'(1));
`endif
    send_pkt(32'hB00, -1, 1'b1);
    chk("t6_glitch_head", pkt_data, {32'hB04, 32'hB03, 32'hB02, 32'hB01, 32'hB00});
    repeat (6) cyc();
    chk("t6_single_pkt", PKT_W'(exp_q.size()), PKT_W'(1));
    send_pkt(32'hC00, -1, 1'b0);
    pkt_ready = 1'b1;
    repeat (5) cyc();
    chk("final_empty", PKT_W'(pkt_valid), '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
